// File: rtl/siso_mux_bank_pkg.sv
// Shared definitions for the SISO mux bank: mode encoding and the
// tap-select width helper used to size every port.
package siso_pkg;

  typedef enum logic {
    SISO_SHIFT  = 1'b0,
    SISO_RECIRC = 1'b1
  } siso_mode_e;

  // Ceiling log2; DEPTH need not be a power of two.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/siso_mux_bank_if.sv
// Control and data bundle for siso_mux_bank; the bench drives the master
// side and the bank sits on the slave side.
interface siso_mux_bank_if
  import siso_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DEPTH = 64,
  localparam int TAPW = clog2(DEPTH)
);

  logic             shift_en;
  siso_mode_e       mode;
  logic             flush;
  logic [LANES-1:0] din;
  logic [TAPW-1:0]  tap_sel;
  logic [LANES-1:0] dout;
  logic             dout_valid;
  logic [TAPW:0]    fill;
  logic             full;

  modport master (
    output shift_en, mode, flush, din, tap_sel,
    input  dout, dout_valid, fill, full
  );

  modport slave (
    input  shift_en, mode, flush, din, tap_sel,
    output dout, dout_valid, fill, full
  );

endinterface

// File: rtl/siso_mux_bank_lane.sv
// One 1-bit shift lane: DEPTH stages, a stage-0 source mux (din or the last
// stage) and a registered tap mux that returns 0 for out-of-range taps.
module siso_lane
  import siso_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int TAPW = clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_shift_en,
  input  siso_mode_e      i_mode,
  input  logic            i_din,
  input  logic [TAPW-1:0] i_tap_sel,
  output logic            o_dout
);

  localparam logic [TAPW:0] DEPTH_W = (TAPW + 1)'(DEPTH);

  logic [DEPTH-1:0] r_stage;
  logic             r_dout;
  logic             w_stage0_in;
  logic             w_tap_bit;

  assign w_stage0_in = (i_mode == SISO_RECIRC) ? r_stage[DEPTH-1] : i_din;

  // Tap values at or beyond DEPTH never index the stage vector.
  always_comb begin
    w_tap_bit = 1'b0;
    if ({1'b0, i_tap_sel} < DEPTH_W) begin
      w_tap_bit = r_stage[i_tap_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
      r_dout  <= 1'b0;
    end else begin
      if (i_shift_en) begin
        r_stage <= {r_stage[DEPTH-2:0], w_stage0_in};
      end
      r_dout <= w_tap_bit;
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/siso_mux_bank.sv
// Bank of LANES parallel shift lanes sharing one fill counter, flush and
// valid tracker; dout/dout_valid are registered one cycle after tap_sel.
module siso_mux_bank
  import siso_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DEPTH = 64,
  localparam int TAPW = clog2(DEPTH)
) (
  input logic            clk,
  input logic            rst,
  siso_mux_bank_if.slave bus
);

  localparam logic [TAPW:0] DEPTH_W  = (TAPW + 1)'(DEPTH);
  localparam logic [TAPW:0] FILL_ONE = (TAPW + 1)'(1);

  logic [TAPW:0]    r_fill;
  logic             r_dout_valid;
  logic [TAPW:0]    w_fill_next;
  logic             w_shift_load;
  logic             w_tap_in_range;
  logic [LANES-1:0] w_dout;

  assign w_shift_load   = bus.shift_en && (bus.mode == SISO_SHIFT);
  assign w_tap_in_range = ({1'b0, bus.tap_sel} < DEPTH_W);

  // A flush that coincides with a SHIFT load keeps the freshly loaded bit.
  always_comb begin
    w_fill_next = r_fill;
    if (bus.flush) begin
      w_fill_next = w_shift_load ? FILL_ONE : '0;
    end else if (w_shift_load && (r_fill != DEPTH_W)) begin
      w_fill_next = r_fill + FILL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_fill       <= w_fill_next;
      r_dout_valid <= w_tap_in_range && (w_fill_next > {1'b0, bus.tap_sel});
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    siso_lane #(
      .DEPTH(DEPTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_shift_en(bus.shift_en),
      .i_mode    (bus.mode),
      .i_din     (bus.din[g]),
      .i_tap_sel (bus.tap_sel),
      .o_dout    (w_dout[g])
    );
  end

  assign bus.dout       = w_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.fill       = r_fill;
  assign bus.full       = (r_fill == DEPTH_W);

endmodule
